// File: rtl/if_fetch_ctrl.sv
// if_fetch_ctrl: controller side of the instruction-fetch interface.
// Steers the fetch PC (advance / redirect), keeps a shadow copy of that PC,
// queues each fetched instruction with its PC, and hands queue entries to
// decode over a valid/ready handshake.
// Optional feature macro: IFQ_BYPASS_EN (zero-latency path from fetch to
// decode when the queue is empty).
module if_fetch_ctrl #(
  parameter int ARQ              = 16,
  parameter int MEMORY_ADDR_SIZE = 13,
  parameter int DEPTH            = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [ARQ-1:0]              if_instr,
  output logic                        if_pc_en,
  output logic                        if_mux_sel,
  output logic [MEMORY_ADDR_SIZE-1:0] if_branch_addr,
  input  logic                        redir_valid,
  input  logic [MEMORY_ADDR_SIZE-1:0] redir_addr,
  output logic                        dq_valid,
  input  logic                        dq_ready,
  output logic [ARQ-1:0]              dq_instr,
  output logic [MEMORY_ADDR_SIZE-1:0] dq_pc,
  output logic [$clog2(DEPTH):0]      dq_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int MAS = MEMORY_ADDR_SIZE;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // Queue storage and control state.
  logic [ARQ-1:0] instr_mem_r [DEPTH];
  logic [MAS-1:0] pc_mem_r    [DEPTH];
  logic [MAS-1:0] pc_r;
  logic [PW-1:0]  wr_ptr_r;
  logic [PW-1:0]  rd_ptr_r;
  logic [CW-1:0]  count_r;

  logic full_s;
  logic empty_s;
  logic pc_en_s;
  logic mux_sel_s;
  logic push_s;
  logic pop_s;
  logic bypass_s;
  logic store_s;
  logic take_s;
  logic dq_valid_s;

  // Handshake decode, fetch steering and decode-side output selection.
  always_comb begin
    full_s    = (count_r == DEPTH_C);
    empty_s   = (count_r == {CW{1'b0}});
    // When full the head is always valid, so a pop while full is just dq_ready;
    // using dq_ready directly keeps pc_en free of a loop through dq_valid.
    pc_en_s   = ~rst & (redir_valid | ~full_s | dq_ready);
    mux_sel_s = ~rst & redir_valid;
    push_s    = pc_en_s & ~redir_valid;
`ifdef IFQ_BYPASS_EN
    bypass_s  = push_s & empty_s & dq_ready;
`else
    bypass_s  = 1'b0;
`endif
    dq_valid_s = ~rst & (~empty_s | bypass_s);
    pop_s      = dq_valid_s & dq_ready;
    // A bypassed instruction is consumed directly and never touches storage.
    store_s    = push_s & ~bypass_s;
    take_s     = pop_s & ~bypass_s;

    if_pc_en   = pc_en_s;
    if_mux_sel = mux_sel_s;
    if (mux_sel_s) begin
      if_branch_addr = redir_addr;
    end else begin
      if_branch_addr = {MAS{1'b0}};
    end
    dq_valid = dq_valid_s;
    dq_count = count_r;
    if (bypass_s) begin
      dq_instr = if_instr;
      dq_pc    = pc_r;
    end else begin
      dq_instr = instr_mem_r[rd_ptr_r];
      dq_pc    = pc_mem_r[rd_ptr_r];
    end
  end

  // Shadow PC tracks the fetch PC register edge for edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r <= {MAS{1'b0}};
    end else if (pc_en_s) begin
      pc_r <= mux_sel_s ? redir_addr : (pc_r + MAS'(1));
    end
  end

  // Pointers and occupancy; a redirect flushes everything, including a same-cycle pop.
  always_ff @(posedge clk) begin
    if (rst || redir_valid) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (store_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (take_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({store_s, take_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry payload write; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (store_s) begin
      instr_mem_r[wr_ptr_r] <= if_instr;
      pc_mem_r[wr_ptr_r]    <= pc_r;
    end
  end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed self-checking bench for if_fetch_ctrl (default build, queue latency 1).
// A small fetch-stage model supplies if_instr = pc + 0x100 for the fetch PC.
module tb_if_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic [15:0] if_instr;
  logic        if_pc_en;
  logic        if_mux_sel;
  logic [12:0] if_branch_addr;
  logic        redir_valid;
  logic [12:0] redir_addr;
  logic        dq_valid;
  logic        dq_ready;
  logic [15:0] dq_instr;
  logic [12:0] dq_pc;
  logic [2:0]  dq_count;

  logic [12:0] fetch_pc;
  int checks;
  int failures;

  if_fetch_ctrl #(.ARQ(16), .MEMORY_ADDR_SIZE(13), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .if_instr(if_instr), .if_pc_en(if_pc_en),
    .if_mux_sel(if_mux_sel), .if_branch_addr(if_branch_addr),
    .redir_valid(redir_valid), .redir_addr(redir_addr),
    .dq_valid(dq_valid), .dq_ready(dq_ready), .dq_instr(dq_instr),
    .dq_pc(dq_pc), .dq_count(dq_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Fetch stage model: PC register plus instruction memory mem[k] = k + 0x100.
  always @(posedge clk) begin
    if (rst) fetch_pc <= 13'h0000;
    else if (if_pc_en) fetch_pc <= if_mux_sel ? if_branch_addr : fetch_pc + 13'h0001;
  end
  assign if_instr = {3'b000, fetch_pc} + 16'h0100;

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    if (obs !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    redir_valid = 1'b0;
    redir_addr = 13'h0000;
    dq_ready = 1'b0;

    // Reset held three cycles with random side inputs.
    for (int i = 0; i < 3; i++) begin
      step;
      redir_valid = 1'($urandom_range(0, 1));
      redir_addr  = 13'($urandom);
      dq_ready    = 1'($urandom_range(0, 1));
      #1;
      chk_val("rst_pc_en", 32'(if_pc_en), 32'd0);
      chk_val("rst_mux_sel", 32'(if_mux_sel), 32'd0);
      chk_val("rst_branch", 32'(if_branch_addr), 32'd0);
      chk_val("rst_dq_valid", 32'(dq_valid), 32'd0);
      chk_val("rst_count", 32'(dq_count), 32'd0);
    end

    // Cycle 0 after release: nothing queued yet, fetch advancing.
    step;
    rst = 1'b0; redir_valid = 1'b0; redir_addr = 13'h0000; dq_ready = 1'b1;
    #1;
    chk_val("s0_valid", 32'(dq_valid), 32'd0);
    chk_val("s0_pc_en", 32'(if_pc_en), 32'd1);
    chk_val("s0_count", 32'(dq_count), 32'd0);

    // Streaming: one instruction per cycle after one cycle of latency.
    for (int c = 1; c <= 6; c++) begin
      step; #1;
      chk_val("str_valid", 32'(dq_valid), 32'd1);
      chk_val("str_pc", 32'(dq_pc), 32'(c - 1));
      chk_val("str_instr", 32'(dq_instr), 32'h100 + 32'(c - 1));
      chk_val("str_count", 32'(dq_count), 32'd1);
    end

    // Back-pressure for 10 cycles: head pc 6 stays put, count saturates at 4.
    for (int c = 7; c <= 16; c++) begin
      step; dq_ready = 1'b0; #1;
      chk_val("bp_head", 32'(dq_pc), 32'd6);
      chk_val("bp_instr", 32'(dq_instr), 32'h106);
      chk_val("bp_count", 32'(dq_count), (c < 10) ? 32'(c - 6) : 32'd4);
      chk_val("bp_pc_en", 32'(if_pc_en), (c < 10) ? 32'd1 : 32'd0);
    end

    // Full + one pop: fetch allowed, count stays at 4, head advances by one.
    step; dq_ready = 1'b1; #1;
    chk_val("fp_pc_en", 32'(if_pc_en), 32'd1);
    chk_val("fp_head", 32'(dq_pc), 32'd6);
    step; dq_ready = 1'b0; #1;
    chk_val("fp_count", 32'(dq_count), 32'd4);
    chk_val("fp_head_next", 32'(dq_pc), 32'd7);

    // Release while full: consecutive PCs, no gap, no duplicate.
    for (int c = 19; c <= 24; c++) begin
      step; dq_ready = 1'b1; #1;
      chk_val("rel_pc", 32'(dq_pc), 32'(c - 12));
      chk_val("rel_count", 32'(dq_count), 32'd4);
    end

    // Redirect to 0x0A0 with a full queue (pc 13..16).
    step; dq_ready = 1'b0; redir_valid = 1'b1; redir_addr = 13'h00A0; #1;
    chk_val("rd_mux_sel", 32'(if_mux_sel), 32'd1);
    chk_val("rd_branch", 32'(if_branch_addr), 32'h0A0);
    chk_val("rd_pc_en", 32'(if_pc_en), 32'd1);
    step; redir_valid = 1'b0; dq_ready = 1'b1; #1;
    chk_val("rd_flush_count", 32'(dq_count), 32'd0);
    chk_val("rd_flush_valid", 32'(dq_valid), 32'd0);
    chk_val("rd_mux_idle", 32'(if_mux_sel), 32'd0);
    chk_val("rd_branch_idle", 32'(if_branch_addr), 32'd0);
    step; #1;
    chk_val("rd_tgt_valid", 32'(dq_valid), 32'd1);
    chk_val("rd_tgt_pc", 32'(dq_pc), 32'h0A0);
    chk_val("rd_tgt_instr", 32'(dq_instr), 32'h1A0);

    // Refill to full (head 0xA1), then redirect while popping.
    step; dq_ready = 1'b0; #1;
    chk_val("rf_pc", 32'(dq_pc), 32'h0A1);
    step; step; step; #1;
    chk_val("rf_count", 32'(dq_count), 32'd4);
    chk_val("rf_pc_en", 32'(if_pc_en), 32'd0);
    step; dq_ready = 1'b1; redir_valid = 1'b1; redir_addr = 13'h1FFE; #1;
    chk_val("rp_valid", 32'(dq_valid), 32'd1);
    chk_val("rp_pc_en", 32'(if_pc_en), 32'd1);
    chk_val("rp_branch", 32'(if_branch_addr), 32'h1FFE);
    step; redir_valid = 1'b0; #1;
    chk_val("rp_count", 32'(dq_count), 32'd0);
    chk_val("rp_valid_gap", 32'(dq_valid), 32'd0);

    // PC wrap past 0x1FFF.
    step; #1;
    chk_val("wr_pc0", 32'(dq_pc), 32'h1FFE);
    chk_val("wr_instr0", 32'(dq_instr), 32'h20FE);
    step; #1;
    chk_val("wr_pc1", 32'(dq_pc), 32'h1FFF);
    chk_val("wr_instr1", 32'(dq_instr), 32'h20FF);
    step; #1;
    chk_val("wr_pc2", 32'(dq_pc), 32'h0000);
    chk_val("wr_instr2", 32'(dq_instr), 32'h0100);

    // Back-to-back redirects: last one wins, neither cycle pushes.
    step; redir_valid = 1'b1; redir_addr = 13'h0050; #1;
    chk_val("bb_branch0", 32'(if_branch_addr), 32'h050);
    step; redir_addr = 13'h0123; #1;
    chk_val("bb_branch1", 32'(if_branch_addr), 32'h123);
    chk_val("bb_count1", 32'(dq_count), 32'd0);
    step; redir_valid = 1'b0; #1;
    chk_val("bb_count2", 32'(dq_count), 32'd0);
    chk_val("bb_valid2", 32'(dq_valid), 32'd0);
    step; #1;
    chk_val("bb_pc", 32'(dq_pc), 32'h123);
    chk_val("bb_instr", 32'(dq_instr), 32'h223);
    step; #1;
    chk_val("bb_pc_next", 32'(dq_pc), 32'h124);

    // Mid-stream reset: outputs forced low, queue dropped, PC back to 0.
    step; rst = 1'b1; redir_valid = 1'b1; redir_addr = 13'h0777; #1;
    chk_val("mr_pc_en", 32'(if_pc_en), 32'd0);
    chk_val("mr_mux_sel", 32'(if_mux_sel), 32'd0);
    chk_val("mr_branch", 32'(if_branch_addr), 32'd0);
    chk_val("mr_valid", 32'(dq_valid), 32'd0);
    step; rst = 1'b0; redir_valid = 1'b0; #1;
    chk_val("mr_count", 32'(dq_count), 32'd0);
    chk_val("mr_valid_after", 32'(dq_valid), 32'd0);
    step; #1;
    chk_val("mr_first_valid", 32'(dq_valid), 32'd1);
    chk_val("mr_first_pc", 32'(dq_pc), 32'h0000);
    chk_val("mr_first_instr", 32'(dq_instr), 32'h0100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
